axil_master_arbiter: RTL and testbench

- Shares the single AXI-Lite register interface between two requesters: requester 0 is the front-panel command path, requester 1 is a background/status poller.
- Round-robin arbitration.
- Sequences each transaction through the full AXI-Lite handshake: AW/W/B for writes, AR/R for reads.
- Returns read data and error status to the granted requester.

---
 rtl/axil_master_arbiter_pkg.sv | 30 +++
 rtl/axil_master_arbiter_if.sv | 63 ++++++
 rtl/axil_master_arbiter_rr_arbiter2.sv | 21 ++
 rtl/axil_master_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_axil_master_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_master_arbiter_pkg.sv
// axil_arb_pkg: shared types for the two-requester AXI-Lite master arbiter.
// Provides FSM state encoding, AXI response codes and a response-error helper.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WR_B = 3'd2,
    S_RD_A = 3'd3,
    S_RD_R = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // EXOKAY has no meaning on AXI-Lite, so it is reported as an error too.
  function automatic logic resp_is_err(input logic [1:0] r);
    logic e;
    unique case (r)
      RESP_OKAY:   e = 1'b0;
      RESP_SLVERR,
      RESP_DECERR: e = 1'b1;
      default:     e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/axil_master_arbiter_if.sv
// axil_master_arbiter_if: requester bundle (req_*/rsp_*) plus AXI-Lite master bus.
// Modport master = arbiter view; modport slave = requesters + AXI slave view.
interface axil_master_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [1:0]          req_valid;
  logic [1:0]          req_wr;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_ready;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;

  logic [ADDR_W-1:0]   m_awaddr;
  logic                m_awvalid;
  logic                m_awready;
  logic [DATA_W-1:0]   m_wdata;
  logic                m_wvalid;
  logic                m_wready;
  logic [1:0]          m_bresp;
  logic                m_bvalid;
  logic                m_bready;
  logic [ADDR_W-1:0]   m_araddr;
  logic                m_arvalid;
  logic                m_arready;
  logic [DATA_W-1:0]   m_rdata;
  logic [1:0]          m_rresp;
  logic                m_rvalid;
  logic                m_rready;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output m_awaddr, m_awvalid,
    input  m_awready,
    output m_wdata, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bvalid,
    output m_bready,
    output m_araddr, m_arvalid,
    input  m_arready,
    input  m_rdata, m_rresp, m_rvalid,
    output m_rready
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  m_awaddr, m_awvalid,
    output m_awready,
    input  m_wdata, m_wvalid,
    output m_wready,
    output m_bresp, m_bvalid,
    input  m_bready,
    input  m_araddr, m_arvalid,
    output m_arready,
    output m_rdata, m_rresp, m_rvalid,
    input  m_rready
  );

endinterface

// File: rtl/axil_master_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational 2-way round-robin pick.
// Ports: req/last_grant/enable in; grant_valid/grant_idx out.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = enable & (|req);
    grant_idx   = 1'b0;
    unique case (1'b1)
      (req == 2'b11): grant_idx = ~last_grant;
      (req == 2'b10): grant_idx = 1'b1;
      default:        grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/axil_master_arbiter.sv
// axil_master_arbiter: shares one AXI-Lite master between two requesters.
// Ports: clk, reset (async, active-high), bus (axil_master_arbiter_if.master).
// Optional: define AXIL_TIMEOUT_EN to abort wait states after TIMEOUT_CYC cycles.
module axil_master_arbiter
  import axil_arb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  axil_master_arbiter_if.master bus
);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              g_q, g_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              awvalid_q, awvalid_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              grant_valid;
  logic              grant_idx;
  logic              wr_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              aw_hs;
  logic              w_hs;

`ifdef AXIL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_q, tmo_d;
  logic          in_wait;
`endif

  rr_arbiter2 u_rr (
    .req         (bus.req_valid),
    .last_grant  (last_q),
    .enable      (state_q == S_IDLE),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign wr_sel    = bus.req_wr[grant_idx];
  assign addr_sel  = bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign wdata_sel = bus.req_wdata[grant_idx*DATA_W +: DATA_W];
  assign aw_hs     = awvalid_q & bus.m_awready;
  assign w_hs      = wvalid_q & bus.m_wready;

  // Grant pulse is combinational so the requester sees it in the IDLE cycle.
  always_comb begin
    bus.req_ready = 2'b00;
    if (grant_valid) bus.req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    g_d         = g_q;
    awaddr_d    = awaddr_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = 2'b00;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          g_d    = grant_idx;
          last_d = grant_idx;
          if (wr_sel) begin
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = addr_sel;
            wdata_d   = wdata_sel;
          end else begin
            state_d   = S_RD_A;
            arvalid_d = 1'b1;
            araddr_d  = addr_sel;
          end
        end
      end
      S_WR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        // Both channels retired, in whatever order they completed.
        if (!awvalid_d && !wvalid_d) begin
          state_d  = S_WR_B;
          bready_d = 1'b1;
        end
      end
      S_WR_B: begin
        if (bus.m_bvalid) begin
          bready_d         = 1'b0;
          state_d          = S_DONE;
          rsp_valid_d[g_q] = 1'b1;
          rsp_err_d        = resp_is_err(bus.m_bresp);
        end
      end
      S_RD_A: begin
        if (bus.m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_R;
        end
      end
      S_RD_R: begin
        if (bus.m_rvalid) begin
          rready_d         = 1'b0;
          state_d          = S_DONE;
          rsp_valid_d[g_q] = 1'b1;
          rsp_err_d        = resp_is_err(bus.m_rresp);
          rsp_rdata_d      = bus.m_rdata;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef AXIL_TIMEOUT_EN
    in_wait = (state_q == S_WR) || (state_q == S_WR_B) ||
              (state_q == S_RD_A) || (state_q == S_RD_R);
    tmo_d = (in_wait && state_d == state_q) ? tmo_q + 1'b1 : '0;
    // Last allowed cycle passed with no progress: abandon the slave.
    if (in_wait && state_d == state_q &&
        tmo_q == CW'(TIMEOUT_CYC - 1)) begin
      awvalid_d        = 1'b0;
      wvalid_d         = 1'b0;
      bready_d         = 1'b0;
      arvalid_d        = 1'b0;
      rready_d         = 1'b0;
      state_d          = S_DONE;
      rsp_valid_d      = 2'b00;
      rsp_valid_d[g_q] = 1'b1;
      rsp_err_d        = 1'b1;
      rsp_rdata_d      = '0;
      tmo_d            = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      g_q         <= 1'b0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef AXIL_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      g_q         <= g_d;
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef AXIL_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign bus.m_awaddr  = awaddr_q;
  assign bus.m_awvalid = awvalid_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.m_wvalid  = wvalid_q;
  assign bus.m_bready  = bready_q;
  assign bus.m_araddr  = araddr_q;
  assign bus.m_arvalid = arvalid_q;
  assign bus.m_rready  = rready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Directed bench for axil_master_arbiter with a responsive AXI-Lite slave
// model and a response scoreboard filled at grant time.
module tb_axil_master_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  axil_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axil_master_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic       err;
    logic [7:0] rdata;
    int         gcyc;
    int         lat;
  } exp_t;

  exp_t sbq[$];
  int   grants[$];
  int   ncmp = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_cfg = 2'b00;
  logic [1:0] rresp_cfg = 2'b00;
  bit   tmo_expect = 1'b0;
  logic [7:0] cap_aw = '0, cap_w = '0, last_ar = '0;
  int   b_cycles = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // AXI-Lite slave: ready/valid after a programmable wait, read data = addr ^ 0x68.
  initial begin
    int awc, wc, bc, arc, rc;
    awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
    bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0;
    bus.m_bresp = 0; bus.m_arready = 0; bus.m_rvalid = 0;
    bus.m_rdata = 0; bus.m_rresp = 0;
    forever begin
      @(posedge clk); #1;
      if (bus.m_awvalid) begin bus.m_awready = (awc >= aw_dly); awc++; end
      else begin bus.m_awready = 0; awc = 0; end
      if (bus.m_wvalid) begin bus.m_wready = (wc >= w_dly); wc++; end
      else begin bus.m_wready = 0; wc = 0; end
      if (bus.m_bready) begin
        bus.m_bvalid = (bc >= b_dly); bus.m_bresp = bresp_cfg; bc++;
      end else begin bus.m_bvalid = 0; bc = 0; end
      if (bus.m_arvalid) begin bus.m_arready = (arc >= ar_dly); arc++; end
      else begin bus.m_arready = 0; arc = 0; end
      if (bus.m_rready) begin
        bus.m_rvalid = (rc >= r_dly); bus.m_rdata = last_ar ^ 8'h68;
        bus.m_rresp = rresp_cfg; rc++;
      end else begin bus.m_rvalid = 0; rc = 0; end
    end
  end

  // Monitor: capture handshakes, police req_ready, score responses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.m_awvalid && bus.m_awready) cap_aw = bus.m_awaddr;
      if (bus.m_wvalid && bus.m_wready) cap_w = bus.m_wdata;
      if (bus.m_arvalid && bus.m_arready) last_ar = bus.m_araddr;
      if (bus.m_bready) b_cycles++;
      if (bus.req_ready != 2'b00) begin
        chk("req_ready_busy",
            {bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.m_arvalid,
             bus.m_rready, |bus.rsp_valid}, 0);
        chk("req_ready_onehot", $onehot(bus.req_ready), 1);
      end
      if (bus.rsp_valid != 2'b00) begin
        if (sbq.size() == 0) begin
          chk("rsp_unexpected", bus.rsp_valid, 0);
        end else begin
          e = sbq.pop_front();
          chk("rsp_valid", bus.rsp_valid, 32'(2'b01 << e.idx));
          chk("rsp_err", bus.rsp_err, e.err);
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          if (e.lat >= 0) chk("rsp_latency", cyc - e.gcyc, e.lat);
        end
      end
    end
  end

  task automatic issue(input int idx, input bit wr, input logic [7:0] addr,
                       input logic [7:0] wdata, input int lat);
    exp_t e;
    int n;
    n = 0;
    bus.req_wr[idx] = wr;
    bus.req_addr[idx*8 +: 8] = addr;
    bus.req_wdata[idx*8 +: 8] = wdata;
    bus.req_valid[idx] = 1'b1;
    do begin @(negedge clk); n++; end
    while (!bus.req_ready[idx] && n < 200);
    if (!bus.req_ready[idx]) begin
      chk("grant_timeout", 0, 1);
    end else begin
      e.idx = idx;
      if (tmo_expect) begin
        e.err = 1'b1; e.rdata = 8'h00;
      end else if (wr) begin
        e.err = (bresp_cfg != 2'b00); e.rdata = 8'h00;
      end else begin
        e.err = (rresp_cfg != 2'b00); e.rdata = addr ^ 8'h68;
      end
      e.gcyc = cyc;
      e.lat = lat;
      sbq.push_back(e);
      grants.push_back(idx);
    end
    @(posedge clk); #1;
    bus.req_valid[idx] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin @(posedge clk); n++; end
    chk("drain", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  logic [2:0] wr_tbl [6];

  initial begin
    bus.req_valid = 0; bus.req_wr = 0; bus.req_addr = 0; bus.req_wdata = 0;
    wr_tbl[0] = 3'b110; wr_tbl[1] = 3'b100; wr_tbl[2] = 3'b100;
    wr_tbl[3] = 3'b100; wr_tbl[4] = 3'b001; wr_tbl[5] = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_valids", {bus.m_awvalid, bus.m_wvalid, bus.m_arvalid}, 0);
    chk("rst_readies", {bus.m_bready, bus.m_rready}, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    reset = 0;
    @(posedge clk); #1;

    // Both requesters contend from reset.
    fork
      begin issue(0, 0, 8'h40, 8'h00, 3); issue(0, 0, 8'h41, 8'h00, 3); end
      begin issue(1, 0, 8'h50, 8'h00, 3); issue(1, 0, 8'h51, 8'h00, 3); end
    join
    drain();
    chk("grant_count", grants.size(), 4);
    if (grants.size() == 4) begin
      chk("grant0", grants[0], 0);
      chk("grant1", grants[1], 1);
      chk("grant2", grants[2], 0);
      chk("grant3", grants[3], 1);
    end

    // Zero-wait write from requester 0.
    issue(0, 1, 8'h12, 8'hA5, 3);
    drain();
    chk("awaddr", cap_aw, 8'h12);
    chk("wdata", cap_w, 8'hA5);

    // Read with a slow arready.
    ar_dly = 4;
    issue(1, 0, 8'h34, 8'h00, -1);
    drain();
    ar_dly = 0;

    // W completes well before AW.
    aw_dly = 3;
    b_cycles = 0;
    issue(0, 1, 8'h66, 8'h99, 6);
    for (int i = 0; i < 6; i++) begin
      chk("wr_phase", {bus.m_awvalid, bus.m_wvalid, bus.m_bready}, wr_tbl[i]);
      @(posedge clk); #1;
    end
    drain();
    chk("b_wait_cycles", b_cycles, 1);
    chk("wr_order_aw", cap_aw, 8'h66);
    chk("wr_order_w", cap_w, 8'h99);
    aw_dly = 0;

    // Error responses.
    rresp_cfg = 2'b10;
    issue(1, 0, 8'h77, 8'h00, 3);
    drain();
    rresp_cfg = 2'b00;
    bresp_cfg = 2'b11;
    issue(1, 1, 8'h20, 8'h3C, 3);
    drain();
    bresp_cfg = 2'b00;

`ifdef AXIL_TIMEOUT_EN
    ar_dly = 1000;
    tmo_expect = 1'b1;
    issue(0, 0, 8'h0F, 8'h00, 9);
    tmo_expect = 1'b0;
    drain();
    chk("tmo_arvalid", bus.m_arvalid, 0);
    ar_dly = 0;
`endif

    // Reset in the middle of a write.
    aw_dly = 20;
    w_dly = 20;
    begin
      int n;
      n = 0;
      bus.req_wr[0] = 1'b1;
      bus.req_addr[7:0] = 8'hC0;
      bus.req_wdata[7:0] = 8'h0D;
      bus.req_valid[0] = 1'b1;
      do begin @(negedge clk); n++; end
      while (!bus.req_ready[0] && n < 200);
      chk("rst_mid_grant", bus.req_ready[0], 1);
      @(posedge clk); #1;
      bus.req_valid[0] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #3;
    chk("pre_rst_awvalid", {bus.m_awvalid, bus.m_wvalid}, 2'b11);
    reset = 1;
    #1;
    chk("rst_mid_valids",
        {bus.m_awvalid, bus.m_wvalid, bus.m_arvalid}, 0);
    chk("rst_mid_readies", {bus.m_bready, bus.m_rready}, 0);
    chk("rst_mid_rsp", bus.rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    aw_dly = 0;
    w_dly = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid_sbq", sbq.size(), 0);

    // Recovery after reset.
    issue(1, 0, 8'h01, 8'h00, 3);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
